fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the program memory, program counter (PC) and instruction register (IR).
- Supplies the 4-bit opcode on IR_CU and the 4-bit operand/jump target; consumes IRload, PCload, Jump_SelMode and Halt from the control unit.
- Includes a load/run/halt mode FSM so a program can be written into memory before execution.

Parameters:
- ADDR_W, 4, PC and program-address width; memory depth = 2**ADDR_W words.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- IRload  in  1  from control unit: IR <= mem[PC].
- PCload  in  1  from control unit: update PC.
- Jump_SelMode  in  1  from control unit: 1 = PC takes jump target, 0 = PC increments.
- Halt  in  1  from control unit: program halted.
- ProgWe  in  1  program write strobe.
- ProgAddr  in  ADDR_W  program write address.
- ProgData  in  8  program word; [7:4] opcode, [3:0] operand.
- ProgStart  in  1  one-cycle pulse that starts execution.
- IR_CU  out  4  IR[7:4], opcode to the control unit.
- Operand  out  4  IR[3:0].
- PC  out  ADDR_W  current program counter.
- Ready  out  1  1 in RUN; top level holds the control unit in reset while 0.
- InstrCount  out  CNT_W  number of IR loads in RUN, saturating.
- WriteErr  out  1  sticky flag: ProgWe was seen in RUN.

Behaviour:
- FSM states: LOAD, RUN, HALTED.
- Reset high (at a clock edge):
  - state=LOAD, PC=0, IR=8'h00, InstrCount=0, WriteErr=0, Ready=0.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-program.
- LOAD:
  - ProgWe=1 → mem[ProgAddr] <= ProgData on that edge.
  - ProgStart=1 → RUN, PC=0, IR=0, InstrCount=0.
  - ProgWe and ProgStart in the same cycle: the write completes, then RUN is entered.
  - IRload, PCload and Halt are ignored.
- RUN:
  - Ready=1.
  - IRload=1 → IR <= mem[PC], using the PC value before this edge. InstrCount increments and saturates at all-ones.
  - PCload=1, Jump_SelMode=0 → PC <= PC+1, wrapping from 2**ADDR_W-1 to 0.
  - PCload=1, Jump_SelMode=1 → PC <= IR[3:0], zero-extended or truncated to ADDR_W.
  - IRload and PCload together: IR takes mem[old PC] and PC updates in the same edge. No extra latency.
  - Jump_SelMode=1 with PCload=0: PC holds.
  - ProgWe=1 → write ignored, WriteErr <= 1.
  - Halt=1 → HALTED on the next edge. Any IRload/PCload in that same cycle is still applied.
  - ProgStart ignored.
- HALTED:
  - Ready=0. PC, IR and InstrCount frozen.
  - IRload and PCload ignored.
  - ProgWe writes memory, as in LOAD.
  - ProgStart=1 → RUN with PC=0, IR=0, InstrCount=0. WriteErr is retained.
- Memory read is combinational from PC. The IR register supplies the one-cycle latency.
- IR_CU and Operand are direct slices of the IR register. PC is a direct register output.
- Illegal state encoding → LOAD with reset values.

Test Plan:
- Reset, then ProgWe writes mem[0]=8'h3A, mem[1]=8'h4B, pulse ProgStart → Ready=1, PC=0, IR_CU=0. After IRload+PCload in one cycle → IR_CU=4'h3, Operand=4'hA, PC=1, InstrCount=1.
- Sequential fetch from PC=15 with PCload=1, Jump_SelMode=0 → PC wraps to 0. IRload in the same cycle loads mem[15].
- IR=8'h7C, PCload=1, Jump_SelMode=1 → PC=12 next edge. A following IRload fetches mem[12].
- In RUN assert Halt with IRload=1 → IR updated, then state HALTED. Further IRload/PCload pulses leave PC, IR and InstrCount unchanged.
- Write mem[2]=8'h55 in RUN → mem[2] unchanged (read back after HALTED→RUN), WriteErr=1 and held through ProgStart. Reset clears it.
- 300 IRload pulses in RUN with CNT_W=8 → InstrCount=255. Reset asserted mid-run → next edge state=LOAD, PC=0, IR=0, InstrCount=0, and memory preserved (verified by rerun).

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: control-unit handshake, program-load bus and status outputs.
// master drives the control/program inputs, slave is the fetch unit itself.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
);
    logic              IRload;
    logic              PCload;
    logic              Jump_SelMode;
    logic              Halt;
    logic              ProgWe;
    logic [ADDR_W-1:0] ProgAddr;
    logic [7:0]        ProgData;
    logic              ProgStart;
    logic [3:0]        IR_CU;
    logic [3:0]        Operand;
    logic [ADDR_W-1:0] PC;
    logic              Ready;
    logic [CNT_W-1:0]  InstrCount;
    logic              WriteErr;

    modport master (
        output IRload, PCload, Jump_SelMode, Halt,
        output ProgWe, ProgAddr, ProgData, ProgStart,
        input  IR_CU, Operand, PC, Ready, InstrCount, WriteErr
    );

    modport slave (
        input  IRload, PCload, Jump_SelMode, Halt,
        input  ProgWe, ProgAddr, ProgData, ProgStart,
        output IR_CU, Operand, PC, Ready, InstrCount, WriteErr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program memory, PC, IR and a load/run/halt mode FSM.
// The control unit is held in reset by the top level while Ready is low.
module fetch_unit #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input logic          Clk,
    input logic          Reset,
    fetch_unit_if.slave  bus_io
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        StLoad   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              werr_q, werr_d;
    logic              mem_we;
    logic [7:0]        mem_q [Depth];
    logic [7:0]        mem_rdata;

    assign mem_rdata = mem_q[pc_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        werr_d  = werr_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StLoad, StHalted: begin
                mem_we = bus_io.ProgWe;
                if (bus_io.ProgStart) begin
                    state_d = StRun;
                    pc_d    = '0;
                    ir_d    = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (bus_io.IRload) begin
                    ir_d = mem_rdata;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Jump target comes from the IR held before this edge.
                if (bus_io.PCload) begin
                    pc_d = bus_io.Jump_SelMode ? ADDR_W'(ir_q[3:0]) : pc_q + ADDR_W'(1);
                end
                if (bus_io.ProgWe) begin
                    werr_d = 1'b1;
                end
                if (bus_io.Halt) begin
                    state_d = StHalted;
                end
            end
            default: begin
                state_d = StLoad;
                pc_d    = '0;
                ir_d    = '0;
                cnt_d   = '0;
                werr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StLoad;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            werr_q  <= werr_d;
        end
    end

    // Program memory survives reset; reset only blocks a write on that edge.
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            mem_q[bus_io.ProgAddr] <= bus_io.ProgData;
        end
    end

    assign bus_io.IR_CU      = ir_q[7:4];
    assign bus_io.Operand    = ir_q[3:0];
    assign bus_io.PC         = pc_q;
    assign bus_io.Ready      = (state_q == StRun);
    assign bus_io.InstrCount = cnt_q;
    assign bus_io.WriteErr   = werr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program scenarios followed by random stimulus,
// every cycle compared against a mode/array reference model.
module tb_fetch_unit;
    logic Clk = 1'b0;
    logic Reset;

    fetch_unit_if #(.ADDR_W(4), .CNT_W(8)) bus ();

    fetch_unit #(.ADDR_W(4), .CNT_W(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .bus_io (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = load, 1 = run, 2 = halted.
    int         m_mode;
    int         m_pc;
    logic [7:0] m_ir;
    int         m_cnt;
    bit         m_werr;
    logic [7:0] m_mem [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_step();
        int         old_pc;
        logic [7:0] old_ir;
        old_pc = m_pc;
        old_ir = m_ir;
        if (Reset) begin
            m_mode = 0; m_pc = 0; m_ir = 8'h00; m_cnt = 0; m_werr = 0;
        end else if (m_mode == 1) begin
            if (bus.IRload) begin
                m_ir = m_mem[old_pc];
                if (m_cnt < 255) m_cnt++;
            end
            if (bus.PCload) m_pc = bus.Jump_SelMode ? int'(old_ir[3:0]) : (old_pc + 1) % 16;
            if (bus.ProgWe) m_werr = 1;
            if (bus.Halt) m_mode = 2;
        end else begin
            if (bus.ProgWe) m_mem[bus.ProgAddr] = bus.ProgData;
            if (bus.ProgStart) begin
                m_mode = 1; m_pc = 0; m_ir = 8'h00; m_cnt = 0;
            end
        end
    endtask

    task automatic check_all();
        check("pc", 32'(bus.PC), 32'(m_pc));
        check("ir_cu", 32'(bus.IR_CU), 32'(m_ir[7:4]));
        check("operand", 32'(bus.Operand), 32'(m_ir[3:0]));
        check("ready", 32'(bus.Ready), 32'(m_mode == 1));
        check("instr_count", 32'(bus.InstrCount), 32'(m_cnt));
        check("write_err", 32'(bus.WriteErr), 32'(m_werr));
    endtask

    task automatic set_in(input bit rst, input bit irl, input bit pcl, input bit jmp,
                          input bit halt, input bit we, input logic [3:0] addr,
                          input logic [7:0] data, input bit start);
        Reset            = rst;
        bus.IRload       = irl;
        bus.PCload       = pcl;
        bus.Jump_SelMode = jmp;
        bus.Halt         = halt;
        bus.ProgWe       = we;
        bus.ProgAddr     = addr;
        bus.ProgData     = data;
        bus.ProgStart    = start;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] prog [16];
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        prog[0]  = 8'h3A;
        prog[1]  = 8'h4B;
        prog[2]  = 8'h21;
        prog[12] = 8'hC5;
        prog[15] = 8'h7C;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hxx;
        m_mode = 0; m_pc = 0; m_ir = 8'h00; m_cnt = 0; m_werr = 0;

        set_in(1, 1, 1, 0, 0, 0, 4'h0, 8'h00, 1);
        tick();
        tick();
        check("reset_ready", 32'(bus.Ready), 32'd0);

        // Load the program; control-unit strobes must be ignored in LOAD.
        for (int i = 0; i < 16; i++) begin
            set_in(0, 1, 1, 1, 1, 1, 4'(i), prog[i], 0);
            tick();
        end
        check("load_pc_ignored", 32'(bus.PC), 32'd0);

        set_in(0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1);
        tick();
        check("start_ready", 32'(bus.Ready), 32'd1);
        check("start_ir_cu", 32'(bus.IR_CU), 32'd0);

        set_in(0, 1, 1, 0, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("first_ir_cu", 32'(bus.IR_CU), 32'h3);
        check("first_operand", 32'(bus.Operand), 32'hA);
        check("first_pc", 32'(bus.PC), 32'd1);
        check("first_count", 32'(bus.InstrCount), 32'd1);

        // Step PC to 15, then fetch with wrap.
        for (int i = 0; i < 14; i++) begin
            set_in(0, 0, 1, 0, 0, 0, 4'h0, 8'h00, 0);
            tick();
        end
        check("pc_before_wrap", 32'(bus.PC), 32'd15);
        set_in(0, 1, 1, 0, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("wrap_pc", 32'(bus.PC), 32'd0);
        check("wrap_ir", {24'd0, bus.IR_CU, bus.Operand}, 32'h7C);

        set_in(0, 0, 0, 1, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("jmp_no_pcload", 32'(bus.PC), 32'd0);
        set_in(0, 0, 1, 1, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("jump_pc", 32'(bus.PC), 32'd12);
        set_in(0, 1, 0, 0, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("jump_fetch", {24'd0, bus.IR_CU, bus.Operand}, 32'hC5);

        set_in(0, 0, 0, 0, 0, 1, 4'h2, 8'h55, 1);
        tick();
        check("run_write_err", 32'(bus.WriteErr), 32'd1);

        set_in(0, 1, 1, 0, 1, 0, 4'h0, 8'h00, 0);
        tick();
        check("halt_ready", 32'(bus.Ready), 32'd0);
        check("halt_pc", 32'(bus.PC), 32'd13);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 1, i[0], 0, 0, 4'h0, 8'h00, 0);
            tick();
        end
        check("halted_pc_frozen", 32'(bus.PC), 32'd13);

        set_in(0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1);
        tick();
        check("restart_werr_kept", 32'(bus.WriteErr), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 0, 0, 0, 4'h0, 8'h00, 0);
            tick();
        end
        check("mem2_unchanged", {24'd0, bus.IR_CU, bus.Operand}, 32'h21);

        set_in(1, 0, 0, 0, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("reset_clears_werr", 32'(bus.WriteErr), 32'd0);

        set_in(0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1);
        tick();
        for (int i = 0; i < 300; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 4'h0, 8'h00, 0);
            tick();
        end
        check("count_saturates", 32'(bus.InstrCount), 32'd255);
        set_in(1, 1, 1, 0, 0, 1, 4'h0, 8'hEE, 1);
        tick();
        check("midrun_reset_count", 32'(bus.InstrCount), 32'd0);
        check("midrun_reset_ready", 32'(bus.Ready), 32'd0);

        set_in(0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 1);
        tick();
        set_in(0, 1, 1, 0, 0, 0, 4'h0, 8'h00, 0);
        tick();
        check("mem_preserved", {24'd0, bus.IR_CU, bus.Operand}, 32'h3A);

        // Random phase.
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                   8'($urandom), $urandom_range(0, 15) == 0);
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
